// File: rtl/hilo_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_ctrl
//   HI/LO register controller for a multi-cycle divider.
//   The controller holds the architectural HI/LO registers and serves
//   mthi/mtlo writes and mfhi/mflo reads. It also runs the request/response
//   handshake with an external divider and stalls the pipeline while a
//   division is in flight.
//
//   Optional build macro: HILO_TIMEOUT_EN
//     When defined, a WAIT-cycle counter aborts a division that has not
//     completed after TIMEOUT_CYCLES cycles and pulses `timeout`.
//     When undefined, WAIT lasts until div_done arrives and `timeout` is 0.
//
//   Ports
//     clk           rising-edge clock
//     reset         synchronous, active-high reset
//     op_div        single-cycle division request (honoured only in IDLE)
//     op_mthi/mtlo  write wdata to HI / LO (honoured only when not busy)
//     wdata         mthi/mtlo write data
//     rd_hi_req     mfhi read request (has priority over rd_lo_req)
//     rd_lo_req     mflo read request
//     div_ctrl      divider enable (high in ISSUE and WAIT)
//     div_done      divider result-valid pulse
//     div_hi/div_lo divider remainder / quotient
//     div_zero      divider divide-by-zero flag
//     hi/lo         architectural HI/LO registers
//     rdata         read data (no write bypass)
//     busy          division in progress (state != IDLE)
//     stall         busy while HI/LO or the divider is being requested
//     div_zero_exc  one-cycle pulse in DONE after a divide-by-zero
//     timeout       one-cycle pulse in DONE after a timeout abort
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no division; mthi/mtlo writes allowed
// ISSUE | first divider-enable cycle; div_done ignored
// WAIT  | waiting for div_done (or timeout)
// DONE  | result visible on hi/lo; flags pulse here
// ---------------------------------------------------------------------------
module hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi_req,
    input  logic        rd_lo_req,
    output logic        div_ctrl,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic        div_zero_exc,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   tmo_hit;

`ifdef HILO_TIMEOUT_EN
    // Counts WAIT cycles without div_done; the last allowed WAIT cycle is
    // TIMEOUT_CYCLES-1, so the abort happens after exactly TIMEOUT_CYCLES
    // WAIT cycles.
    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_CYCLES - 1);

    logic [5:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !div_done) begin
            wait_cnt <= wait_cnt + 6'd1;
        end
    end

    assign tmo_hit = (state == WAIT) && !div_done && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= tmo_hit;
        end
    end
`else
    // Keeps the parameter referenced in builds without the timeout.
    logic [5:0] unused_tmo;
    assign unused_tmo = 6'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_ctrl   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (op_div) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                div_ctrl   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                div_ctrl = 1'b1;
                if (div_done || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Division result wins over a write only in WAIT; writes are accepted in
    // IDLE, including the cycle that starts a division.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == WAIT && div_done && !div_zero) begin
            hi <= div_hi;
            lo <= div_lo;
        end else if (state == IDLE) begin
            if (op_mthi) begin
                hi <= wdata;
            end
            if (op_mtlo) begin
                lo <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_zero_exc <= 1'b0;
        end else begin
            div_zero_exc <= (state == WAIT) && div_done && div_zero;
        end
    end

    assign stall = busy && (rd_hi_req || rd_lo_req || op_mthi || op_mtlo || op_div);
    assign rdata = rd_hi_req ? hi : (rd_lo_req ? lo : 32'd0);

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1, op_div = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
    logic        rd_hi_req = 1'b0, rd_lo_req = 1'b0;
    logic        div_done = 1'b0, div_zero = 1'b0;
    logic [31:0] wdata = '0, div_hi = '0, div_lo = '0;
    logic        div_ctrl, busy, stall, div_zero_exc, timeout;
    logic [31:0] hi, lo, rdata;

    always #5 clk = ~clk;

    hilo_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_div       (op_div),
        .op_mthi      (op_mthi),
        .op_mtlo      (op_mtlo),
        .wdata        (wdata),
        .rd_hi_req    (rd_hi_req),
        .rd_lo_req    (rd_lo_req),
        .div_ctrl     (div_ctrl),
        .div_done     (div_done),
        .div_hi       (div_hi),
        .div_lo       (div_lo),
        .div_zero     (div_zero),
        .hi           (hi),
        .lo           (lo),
        .rdata        (rdata),
        .busy         (busy),
        .stall        (stall),
        .div_zero_exc (div_zero_exc),
        .timeout      (timeout)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        exc;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: architectural view of the block in the current cycle.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0, m_dctl = 1'b0;
    logic        mon_en = 1'b0;
    logic        rd_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("div_ctrl", 32'(div_ctrl), 32'(m_dctl));
            check("stall", 32'(stall),
                  32'(m_busy & (rd_hi_req | rd_lo_req | op_mthi | op_mtlo | op_div)));
            check("rdata", rdata, rd_hi_req ? m_hi : (rd_lo_req ? m_lo : 32'd0));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (busy && !div_ctrl) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop at %0t: completion seen, expected none", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_hi", hi, mon_e.hi);
                    check("done_lo", lo, mon_e.lo);
                    check("done_exc", 32'(div_zero_exc), 32'(mon_e.exc));
                    check("done_tmo", 32'(timeout), 32'(mon_e.tmo));
                end
            end else begin
                check("exc_quiet", 32'(div_zero_exc), 32'd0);
                check("tmo_quiet", 32'(timeout), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!rd_hold) begin
            rd_hi_req = 1'($urandom_range(0, 1));
            rd_lo_req = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wr(input logic h, input logic l, input logic [31:0] d);
        op_mthi = h;
        op_mtlo = l;
        wdata   = d;
        if (!rd_hold) begin
            rd_hi_req = h;
        end
        step();
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
    endtask

    // Division whose div_done arrives in cycle n (op_div in cycle 0).
    task automatic do_div(input int n, input logic [31:0] dh, input logic [31:0] dl,
                          input logic dz, input logic with_wr);
        exp_t        e;
        logic [31:0] w;
        w       = $urandom;
        op_div  = 1'b1;
        op_mthi = with_wr;
        wdata   = w;
        step();
        op_div  = 1'b0;
        op_mthi = 1'b0;
        m_busy  = 1'b1;
        m_dctl  = 1'b1;
        if (with_wr) m_hi = w;
        for (int c = 1; c < n; c++) begin
            // Ignored traffic: op_div and writes while busy, div_done in ISSUE.
            op_div   = ($urandom_range(0, 3) == 0);
            op_mthi  = ($urandom_range(0, 3) == 0);
            op_mtlo  = ($urandom_range(0, 3) == 0);
            wdata    = $urandom;
            div_done = (c == 1);
            div_zero = 1'($urandom_range(0, 1));
            div_hi   = $urandom;
            div_lo   = $urandom;
            step();
        end
        op_div   = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        div_done = 1'b1;
        div_zero = dz;
        div_hi   = dh;
        div_lo   = dl;
        e.hi  = dz ? m_hi : dh;
        e.lo  = dz ? m_lo : dl;
        e.exc = dz;
        e.tmo = 1'b0;
        sb.push_back(e);
        step();
        div_done = 1'b0;
        div_zero = 1'b0;
        m_dctl   = 1'b0;
        if (!dz) begin
            m_hi = dh;
            m_lo = dl;
        end
        step();
        m_busy = 1'b0;
    endtask

`ifdef HILO_TIMEOUT_EN
    task automatic do_timeout();
        exp_t e;
        op_div = 1'b1;
        step();
        op_div = 1'b0;
        m_busy = 1'b1;
        m_dctl = 1'b1;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.exc = 1'b0;
        e.tmo = 1'b1;
        sb.push_back(e);
        for (int c = 0; c < TO; c++) step();
        step();
        m_dctl = 1'b0;
        step();
        m_busy = 1'b0;
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        op_mthi = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        step();
        reset   = 1'b0;
        op_mthi = 1'b0;

        wr(1'b1, 1'b1, 32'hA5A5_0001);
        wr(1'b1, 1'b0, 32'h0000_1234);
        wr(1'b0, 1'b1, 32'h0000_0077);

        do_div(33, 32'd2, 32'd14, 1'b0, 1'b0);
        do_div(5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

        wr(1'b1, 1'b0, 32'h0000_1234);
        do_div(7, $urandom, $urandom, 1'b1, 1'b0);

        rd_hold   = 1'b1;
        rd_hi_req = 1'b0;
        rd_lo_req = 1'b1;
        do_div(12, $urandom, 32'h0BAD_F00D, 1'b0, 1'b0);
        rd_hold   = 1'b0;

        do_div(2, $urandom, $urandom, 1'b0, 1'b1);
        do_div(4, $urandom, $urandom, 1'b1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_div(int'($urandom_range(2, 20)), $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

`ifdef HILO_TIMEOUT_EN
        wr(1'b1, 1'b1, 32'h5555_AAAA);
        do_timeout();
`else
        do_div(60, $urandom, $urandom, 1'b0, 1'b0);
`endif

        // Reset in WAIT cycle 10, then a late div_done that must be ignored.
        wr(1'b1, 1'b1, 32'h0000_4321);
        op_div = 1'b1;
        step();
        op_div = 1'b0;
        m_busy = 1'b1;
        m_dctl = 1'b1;
        for (int c = 0; c < 10; c++) step();
        reset   = 1'b1;
        op_mthi = 1'b1;
        wdata   = 32'hFFFF_0000;
        step();
        reset   = 1'b0;
        op_mthi = 1'b0;
        m_busy  = 1'b0;
        m_dctl  = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        div_done = 1'b1;
        div_zero = 1'b0;
        div_hi   = 32'h1111_1111;
        div_lo   = 32'h2222_2222;
        step();
        div_done = 1'b0;
        step();
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, the number of WAIT cycles before abort (used only with HILO_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port op_div, input, 1, single-cycle division request from the control unit.
REQ-005 SHALL have ports op_mthi and op_mtlo, input, 1 each, write wdata to HI or LO.
REQ-006 SHALL have port wdata, input, 32, mthi/mtlo data.
REQ-007 SHALL have ports rd_hi_req and rd_lo_req, input, 1 each, mfhi/mflo read requests.
REQ-008 SHALL have port div_ctrl, output, 1, enable driven to the divider's DivCtrl.
REQ-009 SHALL have port div_done, input, 1, divider result-valid pulse.
REQ-010 SHALL have ports div_hi and div_lo, input, 32 each, divider remainder and quotient.
REQ-011 SHALL have port div_zero, input, 1, divider divide-by-zero flag.
REQ-012 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.
REQ-013 SHALL have port rdata, output, 32, mfhi/mflo read data.
REQ-014 SHALL have ports busy, stall, div_zero_exc and timeout, output, 1 each.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-016 SHALL move from IDLE to ISSUE on op_div=1; op_div is ignored in every state other than IDLE.
REQ-017 SHALL assert div_ctrl=1 in ISSUE and WAIT, and div_ctrl=0 in IDLE and DONE.
REQ-018 SHALL leave ISSUE for WAIT unconditionally, and SHALL ignore div_done while in ISSUE.
REQ-019 SHALL, in WAIT with div_done=1 and div_zero=0, load hi<=div_hi and lo<=div_lo at that edge and go to DONE.
REQ-020 SHALL, in WAIT with div_done=1 and div_zero=1, leave hi/lo unchanged, pulse div_zero_exc for exactly one cycle (the DONE cycle), and go to DONE.
REQ-021 SHALL go from DONE to IDLE unconditionally.
REQ-022 SHALL meet this latency: op_div in cycle 0, div_ctrl high from cycle 1, div_done in cycle N, hi/lo valid in cycle N+1, busy=0 in cycle N+2.
REQ-023 SHALL drive busy=1 whenever state != IDLE.
REQ-024 SHALL drive stall = busy AND (rd_hi_req OR rd_lo_req OR op_mthi OR op_mtlo OR op_div), combinationally.
REQ-025 SHALL drive rdata combinationally: hi if rd_hi_req, else lo if rd_lo_req, else 0; rd_hi_req has priority when both are set.
REQ-026 SHALL perform op_mthi/op_mtlo writes at the next edge only when busy=0; both may write in the same cycle.
REQ-027 SHALL return the pre-write value on rdata when a read and a write to the same register occur in the same cycle (no bypass).
REQ-028 SHALL, on op_div together with op_mthi/op_mtlo in IDLE, perform the write and start the division; the division result later overwrites.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set state=IDLE, hi=0, lo=0, div_ctrl=0, div_zero_exc=0, timeout=0, and clear the timeout counter.
REQ-030 SHALL abort any division in progress on reset mid-operation; div_ctrl is low in the cycle after the reset edge, and a div_done arriving afterwards is ignored.
REQ-031 SHALL give reset priority over every other input.

Configuration
REQ-032 SHALL, with HILO_TIMEOUT_EN defined, run a 6-bit counter that clears on WAIT entry and increments each WAIT cycle without div_done.
REQ-033 SHALL, with HILO_TIMEOUT_EN defined, go to DONE when the counter reaches TIMEOUT_CYCLES without div_done, leave hi/lo unchanged, and pulse timeout for one cycle.
REQ-034 SHALL, without HILO_TIMEOUT_EN, omit the counter, wait in WAIT indefinitely, and tie timeout to 0.

Verification
REQ-035 SHALL cover: op_div, model returns div_hi=2, div_lo=14 after 33 cycles -> hi=2, lo=14 one cycle after div_done; busy low two cycles after div_done.
REQ-036 SHALL cover: op_div, model returns div_hi=0xFFFFFFFF, div_lo=0xFFFFFFFD (-7/2) -> hi/lo match exactly; div_zero_exc stays 0.
REQ-037 SHALL cover: hi=0x1234, op_div with div_zero=1 at div_done -> hi stays 0x1234; div_zero_exc=1 for one cycle.
REQ-038 SHALL cover: rd_lo_req held during a division -> stall=1 every busy cycle; rdata equals the new lo in the first cycle busy=0.
REQ-039 SHALL cover: reset asserted in WAIT cycle 10, then div_done -> hi=lo=0, state IDLE, div_ctrl=0, no update.
REQ-040 SHALL cover: with HILO_TIMEOUT_EN and no div_done -> timeout pulses after 40 WAIT cycles; hi/lo unchanged; busy clears two cycles later.
